// File: rtl/ms_time_decoder_pkg.sv
// Shared constants, state encoding and the single restoring-division step
// used by the millisecond-count decoder.
package ms_time_decoder_pkg;

  localparam int DVD_W = 32;
  localparam int DVS_W = 22;

  localparam logic [DVS_W-1:0] MS_PER_HOUR = 22'd3_600_000;
  localparam logic [DVS_W-1:0] MS_PER_MIN  = 22'd60_000;
  localparam logic [DVS_W-1:0] MS_PER_SEC  = 22'd1_000;

  localparam int HOUR_W = 11;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int MSF_W  = 10;

  localparam int HOUR_MAX  = 1193;
  localparam int SIXTY_MAX = 59;
  localparam int MILLI_MAX = 999;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV_H,
    ST_DIV_M,
    ST_DIV_S,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [DVS_W-1:0] rem;
    logic [DVD_W-1:0] q;
  } div_step_t;

  // One shift-subtract step. The partial remainder always stays below the
  // divisor, so the 33-bit trial never overflows and 22 stored bits suffice.
  function automatic div_step_t div_step(input logic [DVS_W-1:0] rem,
                                         input logic [DVD_W-1:0] q,
                                         input logic [DVS_W-1:0] d);
    logic [DVD_W:0] trial;
    div_step_t      r;
    trial = {10'd0, rem, q[DVD_W-1]};
    r.q   = {q[DVD_W-2:0], 1'b0};
    r.rem = trial[DVS_W-1:0];
    if (trial >= {11'd0, d}) begin
      r.rem  = trial[DVS_W-1:0] - d;
      r.q[0] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ms_time_decoder_seq_divider.sv
// Restoring sequential divider: the load edge performs the first step, the
// remaining CYCLES-1 edges finish it, then valid holds until the next load.
module seq_divider
  import ms_time_decoder_pkg::*;
#(
  parameter int CYCLES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             valid
);

  localparam int CNT_W = $clog2(CYCLES + 1);

  logic [DVD_W-1:0] shreg;
  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [CNT_W-1:0] count;
  logic             running;
  div_step_t        nxt;

  always_comb begin
    if (load) nxt = div_step('0, dividend, divisor);
    else      nxt = div_step(rem, shreg, dvs);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      rem     <= '0;
      dvs     <= '0;
      count   <= '0;
      running <= 1'b0;
      valid   <= 1'b0;
    end else if (load) begin
      shreg   <= nxt.q;
      rem     <= nxt.rem;
      dvs     <= divisor;
      count   <= CNT_W'(1);
      running <= 1'b1;
      valid   <= 1'b0;
    end else if (running) begin
      shreg <= nxt.q;
      rem   <= nxt.rem;
      count <= count + CNT_W'(1);
      if (count == CNT_W'(CYCLES - 1)) begin
        running <= 1'b0;
        valid   <= 1'b1;
      end
    end
  end

  assign quotient  = shreg;
  assign remainder = rem;

endmodule

// File: rtl/ms_time_decoder.sv
// Decodes a 32-bit millisecond count into h/m/s/ms by running one shared
// sequential divider three times (hour, minute, second divisors).
module ms_time_decoder
  import ms_time_decoder_pkg::*;
#(
  parameter int MS_W       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MS_W-1:0]   nrms,
  output logic              busy,
  output logic              done,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic [MSF_W-1:0]  millis
);

  state_t              state;
  logic [MS_W-1:0]     value;
  logic                load_pend;
  logic [HOUR_W-1:0]   hour_q;
  logic [MIN_W-1:0]    min_q;

  logic                div_load;
  logic [DVD_W-1:0]    div_dividend;
  logic [DVS_W-1:0]    div_divisor;
  logic [DVD_W-1:0]    div_quo;
  logic [DVS_W-1:0]    div_rem;
  logic                div_valid;
  logic                stage_done;

  function automatic logic [HOUR_W-1:0] sat_hour(input logic [DVD_W-1:0] q);
    return (q > DVD_W'(HOUR_MAX)) ? HOUR_W'(HOUR_MAX) : q[HOUR_W-1:0];
  endfunction

  function automatic logic [MIN_W-1:0] sat_sixty(input logic [DVD_W-1:0] q);
    return (q > DVD_W'(SIXTY_MAX)) ? MIN_W'(SIXTY_MAX) : q[MIN_W-1:0];
  endfunction

  function automatic logic [MSF_W-1:0] sat_milli(input logic [DVS_W-1:0] r);
    return (r > DVS_W'(MILLI_MAX)) ? MSF_W'(MILLI_MAX) : r[MSF_W-1:0];
  endfunction

  // A stale valid from the previous request must not be taken while the
  // first stage is still waiting for its load edge.
  assign stage_done = div_valid && !load_pend;

  // The next stage is loaded on the same edge the current one completes,
  // so each stage costs exactly DIV_CYCLES edges.
  always_comb begin
    div_load     = 1'b0;
    div_dividend = value;
    div_divisor  = MS_PER_HOUR;
    if (load_pend) begin
      div_load = 1'b1;
    end else if (stage_done && state == ST_DIV_H) begin
      div_load     = 1'b1;
      div_dividend = {10'd0, div_rem};
      div_divisor  = MS_PER_MIN;
    end else if (stage_done && state == ST_DIV_M) begin
      div_load     = 1'b1;
      div_dividend = {10'd0, div_rem};
      div_divisor  = MS_PER_SEC;
    end
  end

  seq_divider #(
    .CYCLES(DIV_CYCLES)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quo),
    .remainder(div_rem),
    .valid    (div_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      value     <= '0;
      load_pend <= 1'b0;
      hour_q    <= '0;
      min_q     <= '0;
      hours     <= '0;
      minutes   <= '0;
      seconds   <= '0;
      millis    <= '0;
    end else begin
      load_pend <= 1'b0;
      done      <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            value     <= nrms;
            load_pend <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_DIV_H;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DIV_H: begin
          if (stage_done) begin
            hour_q <= sat_hour(div_quo);
            state  <= ST_DIV_M;
          end
        end
        ST_DIV_M: begin
          if (stage_done) begin
            min_q <= sat_sixty(div_quo);
            state <= ST_DIV_S;
          end
        end
        ST_DIV_S: begin
          // All four fields change together on the done edge.
          if (stage_done) begin
            hours   <= hour_q;
            minutes <= min_q;
            seconds <= sat_sixty(div_quo);
            millis  <= sat_milli(div_rem);
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= ST_DONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ms_time_decoder.sv
// Directed bench for ms_time_decoder: reset behaviour, decode values,
// 97-edge latency, ignored starts, back-to-back start and mid-decode reset.
module tb_ms_time_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] nrms;
  logic        busy;
  logic        done;
  logic [10:0] hours;
  logic [5:0]  minutes;
  logic [5:0]  seconds;
  logic [9:0]  millis;

  int checks = 0;
  int errors = 0;

  ms_time_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .nrms   (nrms),
    .busy   (busy),
    .done   (done),
    .hours  (hours),
    .minutes(minutes),
    .seconds(seconds),
    .millis (millis)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_fields(input string tag, input logic [31:0] h, input logic [31:0] m,
                            input logic [31:0] s, input logic [31:0] ms);
    chk({tag, " hours"}, 32'(hours), h);
    chk({tag, " minutes"}, 32'(minutes), m);
    chk({tag, " seconds"}, 32'(seconds), s);
    chk({tag, " millis"}, 32'(millis), ms);
  endtask

  // Called right after the accepting edge; returns edges until done (-1 if
  // none within budget) and how many pre-done samples had busy low.
  task automatic wait_done(output int lat, output int gaps);
    lat  = -1;
    gaps = 0;
    for (int i = 1; i <= 150; i++) begin
      if (busy !== 1'b1) gaps++;
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic decode(input logic [31:0] v, input logic [31:0] h, input logic [31:0] m,
                        input logic [31:0] s, input logic [31:0] ms, input string tag);
    int lat;
    int gaps;
    nrms  = v;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(lat, gaps);
    chk({tag, " latency"}, 32'(lat), 32'd97);
    chk({tag, " busy gaps"}, 32'(gaps), 32'd0);
    chk({tag, " busy on done"}, 32'(busy), 32'd0);
    chk_fields(tag, h, m, s, ms);
    tick();
    chk({tag, " done pulse width"}, 32'(done), 32'd0);
    chk({tag, " hold hours"}, 32'(hours), h);
  endtask

  initial begin
    int bad;
    int lat;
    int gaps;
    int dones;

    // Reset held with start asserted
    rst   = 1'b1;
    start = 1'b1;
    nrms  = 32'd5;
    bad   = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done !== 1'b0) bad++;
      if (busy !== 1'b0) bad++;
    end
    chk("reset busy/done", 32'(bad), 32'd0);
    chk_fields("reset", 0, 0, 0, 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("idle busy", 32'(busy), 32'd0);

    decode(32'd0, 0, 0, 0, 0, "zero");
    decode(32'd3_723_456, 1, 2, 3, 456, "1h2m3s456");
    decode(32'd59_999, 0, 0, 59, 999, "59s999");
    decode(32'hFFFF_FFFF, 1193, 2, 47, 295, "max");
    decode(32'd3_600_000, 1, 0, 0, 0, "1h exact");

    // Starts and nrms changes while busy are ignored
    nrms  = 32'd1000;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = -1;
    for (int i = 1; i <= 150; i++) begin
      if (i == 5 || i == 40 || i == 80) begin
        start = 1'b1;
        nrms  = 32'd7;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done === 1'b1) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    chk("busy-start latency", 32'(lat), 32'd97);
    chk_fields("busy-start", 0, 0, 1, 0);

    // Back-to-back: start asserted during the DONE cycle
    nrms  = 32'd61_001;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b busy after accept", 32'(busy), 32'd1);
    chk("b2b done after accept", 32'(done), 32'd0);
    chk_fields("b2b hold during decode", 0, 0, 1, 0);
    wait_done(lat, gaps);
    chk("b2b latency", 32'(lat), 32'd97);
    chk("b2b busy gaps", 32'(gaps), 32'd0);
    chk_fields("b2b", 0, 1, 1, 1);
    dones = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("no queued start", 32'(dones), 32'd0);
    chk("idle after b2b busy", 32'(busy), 32'd0);

    // Reset at edge k+50 aborts the decode
    nrms  = 32'd3_723_456;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (49) tick();
    chk("mid busy before reset", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk_fields("abort", 0, 0, 0, 0);
    dones = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    chk("abort no done", 32'(dones), 32'd0);
    decode(32'd3_723_456, 1, 2, 3, 456, "after abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
